// File: rtl/nios2_qsys_oci_dct_packer.sv
// nios2_qsys_oci_dct_packer
//
// Producer side of the OCI compressed-trace (DCT) frame interface. Packs
// 2-bit trace atoms into 30-bit frames of up to 15 atoms and presents each
// frame on dct_buffer/dct_count. Also drives the end-of-trace flags.
//
// Handshakes (both interfaces): a transfer happens at a rising clk edge
// where valid && ready are both high. The producer holds its payload stable
// while valid && !ready. atom_ready does not depend on atom_valid, and
// dct_valid does not depend on dct_ready.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   atom_valid     in   atom_data valid this cycle
//   atom_data      in   trace atom (ATOM_W bits)
//   atom_ready     out  packer accepts an atom this cycle (combinational)
//   test_end_req   in   request end of trace and flush (level or pulse)
//   dct_buffer     out  packed frame, atom 0 in the LSBs
//   dct_count      out  number of valid atoms in dct_buffer (1..SLOTS)
//   dct_valid      out  frame present on dct_buffer/dct_count
//   dct_ready      in   sink accepts the frame
//   test_ending    out  flush in progress
//   test_has_ended out  trace complete, sticky until reset
module nios2_qsys_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom_data,
    output logic                    atom_ready,
    input  logic                    test_end_req,
    output logic [ATOM_W*SLOTS-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    dct_valid,
    input  logic                    dct_ready,
    output logic                    test_ending,
    output logic                    test_has_ended
);

    localparam int BUF_W = ATOM_W * SLOTS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
    logic [CNT_W-1:0]   dct_count_q, dct_count_d;
    logic               dct_valid_q, dct_valid_d;
    logic               test_ending_q, test_ending_d;
    logic               test_has_ended_q, test_has_ended_d;

    logic               accept;
    logic               slot_free;
    logic               pending;
    logic               move;
    logic               consume;

    // Gated by reset so that every output reads 0 while reset is held.
    assign atom_ready = !reset && (state_q == COLLECT) && (acc_cnt_q != FULL_CNT);

    assign accept    = atom_valid && atom_ready;
    assign slot_free = !dct_valid_q || dct_ready;
    // A full accumulator is always pending; a partial one only while flushing.
    assign pending   = (acc_cnt_q == FULL_CNT) ||
                       ((state_q == FLUSH) && (acc_cnt_q != '0));
    assign move      = slot_free && pending;
    assign consume   = dct_valid_q && dct_ready;

    always_comb begin
        acc_d            = acc_q;
        acc_cnt_d        = acc_cnt_q;
        dct_buffer_d     = dct_buffer_q;
        dct_count_d      = dct_count_q;
        dct_valid_d      = dct_valid_q;
        state_d          = state_q;

        // Move and accept are mutually exclusive: a move needs a full
        // accumulator (accept blocked) or FLUSH state (accept blocked).
        if (move) begin
            acc_d     = '0;
            acc_cnt_d = '0;
        end else if (accept) begin
            acc_d[{acc_cnt_q, 1'b0} +: ATOM_W] = atom_data;
            acc_cnt_d                          = acc_cnt_q + 1'b1;
        end

        // A move on the same edge as a consume keeps dct_valid high, which
        // gives back-to-back frames.
        if (move) begin
            dct_buffer_d = acc_q;
            dct_count_d  = acc_cnt_q;
            dct_valid_d  = 1'b1;
        end else if (consume) begin
            dct_valid_d  = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (test_end_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Done once the accumulator is empty and the last frame
                // has left the output register.
                if ((acc_cnt_q == '0) && !dct_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        test_ending_d    = (state_d == FLUSH);
        test_has_ended_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= COLLECT;
            acc_q            <= '0;
            acc_cnt_q        <= '0;
            dct_buffer_q     <= '0;
            dct_count_q      <= '0;
            dct_valid_q      <= 1'b0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            acc_cnt_q        <= acc_cnt_d;
            dct_buffer_q     <= dct_buffer_d;
            dct_count_q      <= dct_count_d;
            dct_valid_q      <= dct_valid_d;
            test_ending_q    <= test_ending_d;
            test_has_ended_q <= test_has_ended_d;
        end
    end

    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign dct_valid      = dct_valid_q;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// Testbench for nios2_qsys_oci_dct_packer: directed steps plus a randomized
// phase, with frames checked against a list-of-atoms reference model.
module tb_nios2_qsys_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        test_end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  // Reference model: atoms of the current frame, expected frames {count, buffer}
  int          m_atoms[$];
  logic [33:0] exp_q[$];
  bit          m_ended;

  // Monitor stall tracking
  bit          prev_stall;
  logic [29:0] prev_buf;
  logic [3:0]  prev_cnt;

  nios2_qsys_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .test_end_req   (test_end_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build an expected frame from the collected atoms: atom i weighs 4**i.
  task automatic model_emit();
    longint unsigned v = 0;
    for (int i = 0; i < m_atoms.size(); i++) begin
      v = v + longint'(m_atoms[i]) * (longint'(1) << (2 * i));
    end
    exp_q.push_back({4'(m_atoms.size()), 30'(v)});
    m_atoms.delete();
  endtask

  // Monitor / scoreboard, sampled on the falling edge: what it sees here is
  // what the next rising edge will transfer.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (m_ended) chk("ready_after_end", atom_ready, 1'b0);
      if (prev_stall) begin
        chk("stall_valid", dct_valid, 1'b1);
        chk("stall_stable", {dct_count, dct_buffer}, {prev_cnt, prev_buf});
      end
      if (dct_valid) chk("count_nonzero", dct_count != 4'd0, 1'b1);
      if (dct_valid && dct_ready) begin
        chk("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("frame", {dct_count, dct_buffer}, exp_q.pop_front());
      end
      prev_stall = dct_valid && !dct_ready;
      prev_buf   = dct_buffer;
      prev_cnt   = dct_count;
      if (atom_valid && atom_ready) begin
        m_atoms.push_back(int'(atom_data));
        if (m_atoms.size() == 15) model_emit();
      end
      if (test_end_req && !m_ended) begin
        m_ended = 1'b1;
        if (m_atoms.size() > 0) model_emit();
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    atom_valid   = 1'b0;
    test_end_req = 1'b0;
    m_atoms.delete();
    exp_q.delete();
    m_ended = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic send_atom(input logic [1:0] d);
    int n = 0;
    atom_valid = 1'b1;
    atom_data  = d;
    @(negedge clk);
    while (atom_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("atom_accept", atom_ready, 1'b1);
    tick();
    atom_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (dct_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, dct_valid, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || dct_valid !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_ended(input string tag);
    int n = 0;
    while (test_has_ended !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, test_has_ended, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {atom_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended}, '0);
  endtask

  logic [1:0] d6;

  initial begin
    reset        = 1'b1;
    atom_valid   = 1'b0;
    atom_data    = 2'b00;
    test_end_req = 1'b0;
    dct_ready    = 1'b1;
    m_ended      = 1'b0;
    prev_stall   = 1'b0;
    #3;
    chk_all_zero("reset_outputs");
    do_reset();
    chk("post_reset_ready", atom_ready, 1'b1);
    chk("post_reset_valid", dct_valid, 1'b0);

    // 1: one full frame of 2'b01, one bubble after the 15th accept
    for (int i = 0; i < 15; i++) send_atom(2'b01);
    chk("t1_bubble_ready", atom_ready, 1'b0);
    chk("t1_not_yet_valid", dct_valid, 1'b0);
    tick();
    chk("t1_valid", dct_valid, 1'b1);
    chk("t1_buffer", dct_buffer, 30'h15555555);
    chk("t1_count", dct_count, 4'd15);
    chk("t1_ready_back", atom_ready, 1'b1);
    tick();
    chk("t1_valid_drop", dct_valid, 1'b0);

    // 2: partial frame flushed by a test_end_req pulse
    send_atom(2'd0); send_atom(2'd1); send_atom(2'd2); send_atom(2'd3); send_atom(2'd0);
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    chk("t2_ending", test_ending, 1'b1);
    chk("t2_flush_ready", atom_ready, 1'b0);
    wait_valid("t2_wait_frame");
    chk("t2_buffer", dct_buffer, 30'h000000E4);
    chk("t2_count", dct_count, 4'd5);
    wait_ended("t2_ended");
    chk("t2_ending_low", test_ending, 1'b0);
    chk("t2_drained", exp_q.size(), 0);

    // 3: sink stalled while 30 atoms arrive
    do_reset();
    dct_ready = 1'b0;
    for (int i = 0; i < 30; i++) send_atom(2'b10);
    chk("t3_ready_blocked", atom_ready, 1'b0);
    chk("t3_valid", dct_valid, 1'b1);
    chk("t3_buffer", dct_buffer, 30'h2AAAAAAA);
    chk("t3_count", dct_count, 4'd15);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_still_blocked", atom_ready, 1'b0);
    chk("t3_still_buffer", dct_buffer, 30'h2AAAAAAA);
    dct_ready = 1'b1;
    wait_drain("t3_drained");
    chk("t3_ready_resumed", atom_ready, 1'b1);

    // 4: empty flush
    do_reset();
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    chk("t4_ending", test_ending, 1'b1);
    chk("t4_no_valid", dct_valid, 1'b0);
    tick();
    chk("t4_ending_low", test_ending, 1'b0);
    chk("t4_has_ended", test_has_ended, 1'b1);
    atom_valid   = 1'b1;
    atom_data    = 2'b11;
    test_end_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_ignore_ready", atom_ready, 1'b0);
      chk("t4_ignore_valid", dct_valid, 1'b0);
      chk("t4_sticky", test_has_ended, 1'b1);
    end
    atom_valid   = 1'b0;
    test_end_req = 1'b0;

    // 5: async reset mid-frame and mid-flush
    do_reset();
    for (int i = 0; i < 7; i++) send_atom(2'($urandom_range(0, 3)));
    #2 reset = 1'b1;
    m_atoms.delete();
    #1 chk_all_zero("t5_reset_midframe");
    do_reset();
    dct_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_atom(2'($urandom_range(0, 3)));
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    wait_valid("t5_flush_frame");
    chk("t5_flushing", test_ending, 1'b1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 chk_all_zero("t5_reset_midflush");
    do_reset();
    dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_atom(2'($urandom_range(0, 3)));
    wait_valid("t5_clean_frame");
    chk("t5_count", dct_count, 4'd15);
    wait_drain("t5_drained");

    // 6: atom accepted on the same edge test_end_req is sampled
    do_reset();
    for (int i = 0; i < 3; i++) send_atom(2'($urandom_range(0, 3)));
    d6           = 2'($urandom_range(0, 3));
    atom_valid   = 1'b1;
    atom_data    = d6;
    test_end_req = 1'b1;
    tick();
    atom_valid   = 1'b0;
    test_end_req = 1'b0;
    wait_valid("t6_frame");
    chk("t6_count", dct_count, 4'd4);
    chk("t6_last_atom", dct_buffer[7:6], d6);
    wait_ended("t6_ended");

    // 7: random traffic with random sink stalls, then flush
    do_reset();
    for (int i = 0; i < 400; i++) begin
      atom_valid = 1'($urandom_range(0, 1));
      atom_data  = 2'($urandom_range(0, 3));
      dct_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    atom_valid   = 1'b0;
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    dct_ready    = 1'b1;
    wait_ended("t7_ended");
    chk("t7_drained", exp_q.size(), 0);
    chk("t7_no_valid", dct_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
